// File: rtl/carry_select_adder_pkg.sv
// Shared constants and a golden-sum helper for the carry-select adder.
// The helper is used only by the testbench and is not called by the RTL.
package csa_pkg;

    localparam int CSA_WIDTH_DEF = 4;
    localparam int CSA_BLOCK_DEF = 2;

    // Result is {Cout, S}: the full (WIDTH+1)-bit unsigned sum at the default width.
    function automatic logic [CSA_WIDTH_DEF:0] ref_add(
        input logic [CSA_WIDTH_DEF-1:0] a,
        input logic [CSA_WIDTH_DEF-1:0] b,
        input logic                     cin
    );
        return {1'b0, a} + {1'b0, b} + {{CSA_WIDTH_DEF{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/carry_select_adder_if.sv
// Operand/result bundle for the carry-select adder.
// The master drives operands; the slave (the adder) returns the registered result.
interface carry_select_adder_if #(
    parameter int WIDTH = 4
);
    // Handshake: in_valid qualifies A/B/Cin on a rising edge. out_valid is high for
    // exactly the cycle after such an edge. There is no ready or backpressure.
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    modport master (output in_valid, A, B, Cin, input S, Cout, out_valid);
    modport slave  (input in_valid, A, B, Cin, output S, Cout, out_valid);
endinterface

// File: rtl/carry_select_adder_rca_block.sv
// BLOCK-bit ripple-carry adder built from full-adder equations.
module rca_block #(
    parameter int BLOCK = 2
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             co
);
    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/carry_select_adder.sv
// WIDTH-bit carry-select adder with a single registered output stage.
// The output register is cleared asynchronously by rst_n.
module carry_select_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,
    parameter int BLOCK = CSA_BLOCK_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    carry_select_adder_if.slave bus
);
    localparam int NB = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_width
        $fatal(1, "carry_select_adder: WIDTH must be a multiple of BLOCK");
    end

    logic [BLOCK-1:0] s_c0  [NB];
    logic [BLOCK-1:0] s_c1  [NB];
    logic             co_c0 [NB];
    logic             co_c1 [NB];

    for (genvar k = 0; k < NB; k++) begin : g_blk
        if (k == 0) begin : g_first
            // Block 0 sees the real carry-in, so both select arms carry the same result.
            rca_block #(.BLOCK(BLOCK)) u_rca (
                .a  (bus.A[BLOCK-1:0]),
                .b  (bus.B[BLOCK-1:0]),
                .ci (bus.Cin),
                .s  (s_c0[0]),
                .co (co_c0[0])
            );
            assign s_c1[0]  = s_c0[0];
            assign co_c1[0] = co_c0[0];
        end else begin : g_upper
            rca_block #(.BLOCK(BLOCK)) u_rca0 (
                .a  (bus.A[k*BLOCK +: BLOCK]),
                .b  (bus.B[k*BLOCK +: BLOCK]),
                .ci (1'b0),
                .s  (s_c0[k]),
                .co (co_c0[k])
            );
            rca_block #(.BLOCK(BLOCK)) u_rca1 (
                .a  (bus.A[k*BLOCK +: BLOCK]),
                .b  (bus.B[k*BLOCK +: BLOCK]),
                .ci (1'b1),
                .s  (s_c1[k]),
                .co (co_c1[k])
            );
        end
    end

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    // The selected carry of each block picks the sum and carry of the next block.
    always_comb begin
        cout_d = bus.Cin;
        sum_d  = '0;
        for (int k = 0; k < NB; k++) begin
            sum_d[k*BLOCK +: BLOCK] = cout_d ? s_c1[k] : s_c0[k];
            cout_d                  = cout_d ? co_c1[k] : co_c0[k];
        end
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign bus.S         = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_carry_select_adder.sv
// Testbench for carry_select_adder: an arithmetic reference model checked every cycle,
// plus hand-computed literal results for the directed vectors.
module tb_carry_select_adder;
    import csa_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst_n;

    carry_select_adder_if #(.WIDTH(W)) bus ();

    carry_select_adder #(.WIDTH(W), .BLOCK(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: expected {out_valid, Cout, S}.
    logic [W:0] exp_sum;
    logic       exp_v;

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got {v,cout,s}=%b required %b at t=%0t", name, act, req, $time);
        end
    endtask

    // compare process: updates the model at every edge or reset assertion, then checks.
    initial begin
        exp_sum = '0;
        exp_v   = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_sum = '0;
                exp_v   = 1'b0;
            end else begin
                if (bus.in_valid) exp_sum = ref_add(bus.A, bus.B, bus.Cin);
                exp_v = bus.in_valid;
            end
            #1;
            check("model", {bus.out_valid, bus.Cout, bus.S}, {exp_v, exp_sum});
        end
    end

    // driver tasks
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic v);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        bus.in_valid = v;
    endtask

    task automatic expect_lit(input string name, input logic [W+1:0] req);
        @(posedge clk);
        #1;
        check(name, {bus.out_valid, bus.Cout, bus.S}, req);
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.A        = 4'hF;
        bus.B        = 4'hF;
        bus.Cin      = 1'b1;
        bus.in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_no_clock", {bus.out_valid, bus.Cout, bus.S}, 6'b0_0_0000);
        expect_lit("reset_held", 6'b0_0_0000);
        expect_lit("reset_held2", 6'b0_0_0000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        drive(4'hF, 4'h1, 1'b0, 1'b1);
        expect_lit("wrap", 6'b1_1_0000);
        drive(4'hF, 4'h0, 1'b1, 1'b1);
        expect_lit("cin_ripple", 6'b1_1_0000);
        drive(4'h5, 4'h3, 1'b1, 1'b1);
        expect_lit("mid_value", 6'b1_0_1001);
        drive(4'h8, 4'h8, 1'b0, 1'b1);
        expect_lit("top_carry", 6'b1_1_0000);
        drive(4'h3, 4'h1, 1'b0, 1'b1);
        expect_lit("block_carry", 6'b1_0_0100);

        // exhaustive, back-to-back
        for (int i = 0; i < 512; i++) begin
            logic [8:0] vec;
            vec = i[8:0];
            drive(vec[8:5], vec[4:1], vec[0], 1'b1);
        end
        // random vectors, one per clock
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        end

        // hold: 6+7+0 = 13, then three idle cycles with changing operands
        drive(4'h6, 4'h7, 1'b0, 1'b1);
        expect_lit("hold_load", 6'b1_0_1101);
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            expect_lit("hold_idle", 6'b0_0_1101);
        end

        // async reset mid-stream: 9+9+1 = 19 captured, next vector discarded
        drive(4'h9, 4'h9, 1'b1, 1'b1);
        expect_lit("pre_reset", 6'b1_1_0011);
        drive(4'hA, 4'h7, 1'b0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid", {bus.out_valid, bus.Cout, bus.S}, 6'b0_0_0000);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.A        = 4'h2;
        bus.B        = 4'h3;
        bus.Cin      = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        check("after_release", {bus.out_valid, bus.Cout, bus.S}, 6'b0_0_0000);
        expect_lit("first_after_reset", 6'b1_0_0101);

        drive(4'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
